// File: rtl/fpu_add_sub_operand_stage.sv
// Operand unpack/classify stage ahead of the FP add/sub datapath.
// Decodes binary32 operands and rounding mode, then buffers them in a main + skid register pair.
module fpu_add_sub_operand_stage #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               flush_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [EXP_W+MAN_W:0] opA_i,
  input  logic [EXP_W+MAN_W:0] opB_i,
  input  logic               sub_i,
  input  logic [2:0]         rm_i,
  input  logic [2:0]         frm_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic               sign_A_o,
  output logic               sign_B_o,
  output logic [EXP_W-1:0]   exp_A_o,
  output logic [EXP_W-1:0]   exp_B_o,
  output logic [MAN_W:0]     sig_A_o,
  output logic [MAN_W:0]     sig_B_o,
  output logic               isZeroA_o,
  output logic               isInfA_o,
  output logic               isNaNA_o,
  output logic               isZeroB_o,
  output logic               isInfB_o,
  output logic               isNaNB_o,
  output logic               isSignaling_o,
  output logic               sub_op_o,
  output logic [2:0]         rounding_mode_o,
  output logic               illegal_rm_o
);

  localparam int unsigned OP_W = 1 + EXP_W + MAN_W;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W:0]   sig;
    logic             is_zero;
    logic             is_inf;
    logic             is_nan;
    logic             is_snan;
  } operand_t;

  typedef struct packed {
    operand_t   a;
    operand_t   b;
    logic       sub_op;
    logic [2:0] rm;
    logic       illegal_rm;
  } entry_t;

  function automatic operand_t unpack_op(input logic [OP_W-1:0] op);
    operand_t         res;
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] m;
    e           = op[OP_W-2 -: EXP_W];
    m           = op[MAN_W-1:0];
    res.sign    = op[OP_W-1];
    res.exp     = e;
    res.sig     = {(e != '0), m};
    res.is_zero = (e == '0) && (m == '0);
    res.is_inf  = (&e) && (m == '0);
    res.is_nan  = (&e) && (m != '0);
    res.is_snan = (&e) && (m != '0) && !m[MAN_W-1];
    return res;
  endfunction

  entry_t     w_new;
  entry_t     w_m_nxt;
  entry_t     w_s_nxt;
  entry_t     r_m;
  entry_t     r_s;
  logic       r_m_valid;
  logic       r_s_valid;
  logic       w_m_valid_nxt;
  logic       w_s_valid_nxt;
  logic       w_accept;
  logic       w_drain;
  logic [2:0] w_rm_res;
  logic       w_rm_bad;

  assign w_accept = valid_i && !r_s_valid;
  assign w_drain  = r_m_valid && ready_i;

  // Field decode and dynamic rounding-mode resolution; illegal modes collapse to RNE and flag a trap.
  always_comb begin
    w_rm_res         = (rm_i == 3'b111) ? frm_i : rm_i;
    w_rm_bad         = (w_rm_res > 3'd4);
    w_new.a          = unpack_op(opA_i);
    w_new.b          = unpack_op(opB_i);
    w_new.sub_op     = sub_i;
    w_new.rm         = w_rm_bad ? 3'b000 : w_rm_res;
    w_new.illegal_rm = w_rm_bad;
  end

  // Main/skid steering: skid only fills when main is occupied and not draining.
  always_comb begin
    w_m_valid_nxt = r_m_valid;
    w_s_valid_nxt = r_s_valid;
    w_m_nxt       = r_m;
    w_s_nxt       = r_s;
    if (flush_i) begin
      w_m_valid_nxt = 1'b0;
      w_s_valid_nxt = 1'b0;
    end else if (!r_m_valid || w_drain) begin
      if (r_s_valid) begin
        w_m_nxt       = r_s;
        w_m_valid_nxt = 1'b1;
        w_s_valid_nxt = w_accept;
        if (w_accept) w_s_nxt = w_new;
      end else begin
        w_m_valid_nxt = w_accept;
        if (w_accept) w_m_nxt = w_new;
      end
    end else if (w_accept) begin
      w_s_nxt       = w_new;
      w_s_valid_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_m_valid <= 1'b0;
      r_s_valid <= 1'b0;
      r_m       <= '0;
      r_s       <= '0;
    end else begin
      r_m_valid <= w_m_valid_nxt;
      r_s_valid <= w_s_valid_nxt;
      r_m       <= w_m_nxt;
      r_s       <= w_s_nxt;
    end
  end

  assign ready_o         = !r_s_valid;
  assign valid_o         = r_m_valid;
  assign sign_A_o        = r_m.a.sign;
  assign sign_B_o        = r_m.b.sign;
  assign exp_A_o         = r_m.a.exp;
  assign exp_B_o         = r_m.b.exp;
  assign sig_A_o         = r_m.a.sig;
  assign sig_B_o         = r_m.b.sig;
  assign isZeroA_o       = r_m.a.is_zero;
  assign isInfA_o        = r_m.a.is_inf;
  assign isNaNA_o        = r_m.a.is_nan;
  assign isZeroB_o       = r_m.b.is_zero;
  assign isInfB_o        = r_m.b.is_inf;
  assign isNaNB_o        = r_m.b.is_nan;
  assign isSignaling_o   = r_m.a.is_snan || r_m.b.is_snan;
  assign sub_op_o        = r_m.sub_op;
  assign rounding_mode_o = r_m.rm;
  assign illegal_rm_o    = r_m.illegal_rm;

endmodule
